// File: rtl/vending_machine_param.sv
// -----------------------------------------------------------------------------
// vending_machine_param
// Snack vending controller for a NUM_ROWS x NUM_COLS slot array. Each slot
// keeps its own stock count and each row has its own price. It sequences the
// card / two-key / payment handshake, times out idle key entry and payment,
// and reports sold-out separately from invalid item codes.
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for CARD_IN; RELOAD restocks every slot here
// KEY1   | waiting for the row key (timed)
// KEY2   | waiting for the column key (timed)
// CHECK  | one cycle: validate code, then check stock
// PAY    | price shown on COST, waiting for VALID_TRAN (timed)
// DO_VEND| VEND pulse, selected slot decrements
// INVALID| INVALID_SEL pulse
// SOLDOUT| SOLD_OUT pulse
// FAIL   | FAILED_TRAN pulse (payment timed out)
// TOUT   | TIMEOUT pulse (key entry timed out)
//
// Ports
//   CLK          in   clock, rising edge
//   RESET_N      in   asynchronous active-low reset
//   RELOAD       in   restock all slots (IDLE only, beats CARD_IN)
//   CARD_IN      in   start a transaction (IDLE only)
//   ITEM_CODE    in   key value, sampled with KEY_PRESS
//   KEY_PRESS    in   single-cycle key strobe
//   VALID_TRAN   in   payment approved
//   VEND         out  one-cycle vend pulse
//   INVALID_SEL  out  one-cycle pulse, code out of range
//   SOLD_OUT     out  one-cycle pulse, selected slot empty
//   FAILED_TRAN  out  one-cycle pulse, payment timed out
//   TIMEOUT      out  one-cycle pulse, key entry timed out
//   COST         out  price of the selected row while in PAY, else 0
//   VEND_ROW/COL out  latched selection, nonzero only while VEND=1
//   BUSY         out  high in every state except IDLE
// -----------------------------------------------------------------------------
module vending_machine_param #(
  parameter int NUM_ROWS     = 2,
  parameter int NUM_COLS     = 5,
  parameter int CODE_W       = 3,
  parameter int STOCK_W      = 4,
  parameter int RELOAD_COUNT = 10,
  parameter int COST_W       = 3,
  parameter logic [NUM_ROWS*COST_W-1:0] ROW_COST = {3'd5, 3'd2},
  parameter int KEY_TIMEOUT  = 5,
  parameter int PAY_TIMEOUT  = 5
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              RELOAD,
  input  logic              CARD_IN,
  input  logic [CODE_W-1:0] ITEM_CODE,
  input  logic              KEY_PRESS,
  input  logic              VALID_TRAN,
  output logic              VEND,
  output logic              INVALID_SEL,
  output logic              SOLD_OUT,
  output logic              FAILED_TRAN,
  output logic              TIMEOUT,
  output logic [COST_W-1:0] COST,
  output logic [CODE_W-1:0] VEND_ROW,
  output logic [CODE_W-1:0] VEND_COL,
  output logic              BUSY
);

  localparam int NSLOT   = NUM_ROWS * NUM_COLS;
  localparam int TMR_MAX = (KEY_TIMEOUT > PAY_TIMEOUT) ? KEY_TIMEOUT : PAY_TIMEOUT;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] KEY_LAST = TMR_W'(KEY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] PAY_LAST = TMR_W'(PAY_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_KEY1, S_KEY2, S_CHECK, S_PAY,
    S_DO_VEND, S_INVALID, S_SOLDOUT, S_FAIL, S_TOUT
  } state_t;

  state_t                     state_q, state_d;
  logic [CODE_W-1:0]          row_q, row_d;
  logic [CODE_W-1:0]          col_q, col_d;
  logic [TMR_W-1:0]           tmr_q, tmr_d;
  // Slot i = (row-1)*NUM_COLS + col, packed flat so every slot is one field.
  logic [NSLOT*STOCK_W-1:0]   stock_q, stock_d;

  logic                       code_valid;
  int                         sel_idx;
  logic [STOCK_W-1:0]         sel_stock;
  logic [COST_W-1:0]          cost_sel;

  always_comb begin
    code_valid = (row_q != '0) && (int'(row_q) <= NUM_ROWS) && (int'(col_q) < NUM_COLS);
    sel_idx    = (int'(row_q) - 1) * NUM_COLS + int'(col_q);
  end

  // Out-of-range indices match no slot and read as zero; CHECK rejects them
  // on code_valid before stock is ever consulted.
  always_comb begin
    sel_stock = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (i == sel_idx) sel_stock = stock_q[i*STOCK_W +: STOCK_W];
    end
  end

  always_comb begin
    cost_sel = '0;
    for (int r = 1; r <= NUM_ROWS; r++) begin
      if (int'(row_q) == r) cost_sel = ROW_COST[(r-1)*COST_W +: COST_W];
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tmr_d   = tmr_q;
    stock_d = stock_q;
    unique case (state_q)
      S_IDLE: begin
        if (RELOAD) begin
          for (int i = 0; i < NSLOT; i++) stock_d[i*STOCK_W +: STOCK_W] = STOCK_W'(RELOAD_COUNT);
        end else if (CARD_IN) begin
          state_d = S_KEY1;
          tmr_d   = '0;
        end
      end
      S_KEY1: begin
        if (KEY_PRESS) begin
          row_d   = ITEM_CODE;
          state_d = S_KEY2;
          tmr_d   = '0;
        end else if (tmr_q == KEY_LAST) begin
          state_d = S_TOUT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_KEY2: begin
        if (KEY_PRESS) begin
          col_d   = ITEM_CODE;
          state_d = S_CHECK;
          tmr_d   = '0;
        end else if (tmr_q == KEY_LAST) begin
          state_d = S_TOUT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_CHECK: begin
        if (!code_valid) begin
          state_d = S_INVALID;
        end else if (sel_stock == '0) begin
          state_d = S_SOLDOUT;
        end else begin
          state_d = S_PAY;
          tmr_d   = '0;
        end
      end
      S_PAY: begin
        if (VALID_TRAN) begin
          state_d = S_DO_VEND;
        end else if (tmr_q == PAY_LAST) begin
          state_d = S_FAIL;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_DO_VEND: begin
        // Only a slot that passed the nonzero check in CHECK gets here.
        for (int i = 0; i < NSLOT; i++) begin
          if (i == sel_idx) stock_d[i*STOCK_W +: STOCK_W] = stock_q[i*STOCK_W +: STOCK_W] - STOCK_W'(1);
        end
        state_d = S_IDLE;
      end
      S_INVALID, S_SOLDOUT, S_FAIL, S_TOUT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      tmr_q   <= '0;
      stock_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tmr_q   <= tmr_d;
      stock_q <= stock_d;
    end
  end

  assign VEND        = (state_q == S_DO_VEND);
  assign INVALID_SEL = (state_q == S_INVALID);
  assign SOLD_OUT    = (state_q == S_SOLDOUT);
  assign FAILED_TRAN = (state_q == S_FAIL);
  assign TIMEOUT     = (state_q == S_TOUT);
  assign BUSY        = (state_q != S_IDLE);
  assign COST        = (state_q == S_PAY) ? cost_sel : '0;
  assign VEND_ROW    = VEND ? row_q : '0;
  assign VEND_COL    = VEND ? col_q : '0;

endmodule
